usb_packet_tx: RTL

//  USB FS/LS packet transmitter; the send-side counterpart to the proxy's packet receiver.

---
 rtl/usb_packet_tx.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_packet_tx.sv
// USB FS/LS packet transmitter: SYNC, PID, token+CRC5 or payload+CRC16, EOP,
// with bit stuffing, NRZI line coding and a pad output enable.
module usb_packet_tx #(
    parameter int FS_DIV = 4,
    parameter int LS_DIV = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_fs,
    input  logic        start,
    input  logic [7:0]  pid,
    input  logic [10:0] token,
    input  logic [10:0] payload_len,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_dp,
    output logic        tx_dm,
    output logic        tx_oe,
    output logic        busy,
    output logic        done,
    output logic        underrun
);
    localparam int MAXDIV = (LS_DIV > FS_DIV) ? LS_DIV : FS_DIV;
    localparam int CW     = $clog2(MAXDIV);

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_TOKEN, S_CRC5, S_DATA, S_CRC16, S_UNDR, S_EOP_SE0, S_EOP_J
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [2:0]    ones_q, ones_d;
    logic          line_q, line_d;      // 1 = J, 0 = K
    logic          se0_q, se0_d;
    logic          oe_q, oe_d;
    logic          fs_q, fs_d;
    logic          done_q, done_d;
    logic          undr_q, undr_d;
    logic          undr_pend_q, undr_pend_d;
    logic [7:0]    pid_q, pid_d;
    logic [10:0]   tok_q, tok_d;
    logic [7:0]    sh_q, sh_d;
    logic [4:0]    crc5_q, crc5_d;
    logic [15:0]   crc16_q, crc16_d;
    logic [10:0]   left_q, left_d;
    logic          load_byte;
    logic          nb;
    logic          bit_end;
    logic          stuff_region;
    logic [CW-1:0] div_m1;

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = b ^ c[4];
        return {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    assign div_m1       = fs_q ? CW'(FS_DIV - 1) : CW'(LS_DIV - 1);
    assign bit_end      = (cnt_q == div_m1);
    assign stuff_region = state_q inside {S_PID, S_TOKEN, S_CRC5, S_DATA, S_CRC16};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            ones_q      <= '0;
            line_q      <= 1'b1;
            se0_q       <= 1'b0;
            oe_q        <= 1'b0;
            fs_q        <= 1'b1;
            done_q      <= 1'b0;
            undr_q      <= 1'b0;
            undr_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ones_q      <= ones_d;
            line_q      <= line_d;
            se0_q       <= se0_d;
            oe_q        <= oe_d;
            fs_q        <= fs_d;
            done_q      <= done_d;
            undr_q      <= undr_d;
            undr_pend_q <= undr_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        pid_q   <= pid_d;
        tok_q   <= tok_d;
        sh_q    <= sh_d;
        crc5_q  <= crc5_d;
        crc16_q <= crc16_d;
        left_q  <= left_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        ones_d      = ones_q;
        line_d      = line_q;
        se0_d       = se0_q;
        oe_d        = oe_q;
        fs_d        = fs_q;
        done_d      = 1'b0;
        undr_d      = 1'b0;
        undr_pend_d = undr_pend_q;
        pid_d       = pid_q;
        tok_d       = tok_q;
        sh_d        = sh_q;
        crc5_d      = crc5_q;
        crc16_d     = crc16_q;
        left_d      = left_q;
        load_byte   = 1'b0;
        nb          = 1'b0;
        if (state_q == S_IDLE) begin
            // the clk after done is blocked so a held start cannot retrigger
            if (start && !done_q) begin
                state_d     = S_SYNC;
                cnt_d       = '0;
                idx_d       = '0;
                ones_d      = '0;
                line_d      = 1'b0;
                se0_d       = 1'b0;
                oe_d        = 1'b1;
                fs_d        = is_fs;
                undr_pend_d = 1'b0;
                pid_d       = pid;
                tok_d       = token;
                left_d      = payload_len;
                crc5_d      = 5'h1F;
                crc16_d     = 16'hFFFF;
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            if (stuff_region && ones_q == 3'd6) begin
                // stuffed 0: field position is held, so the next advance resumes from it
                ones_d = '0;
                line_d = ~line_q;
            end else begin
                case (state_q)
                    S_SYNC: begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd7) begin
                            state_d = S_PID;
                            idx_d   = '0;
                        end
                    end
                    S_PID: begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd7) begin
                            idx_d = '0;
                            case (pid_q[1:0])
                                2'b01:   state_d = S_TOKEN;
                                2'b11:   state_d = (left_q == '0) ? S_CRC16 : S_DATA;
                                default: state_d = S_EOP_SE0;
                            endcase
                        end
                    end
                    S_TOKEN: begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd10) begin
                            state_d = S_CRC5;
                            idx_d   = '0;
                        end
                    end
                    S_CRC5: begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd4) begin
                            state_d = S_EOP_SE0;
                            idx_d   = '0;
                        end
                    end
                    S_DATA: begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd7) begin
                            state_d = (left_q == '0) ? S_CRC16 : S_DATA;
                            idx_d   = '0;
                        end
                    end
                    S_CRC16: begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            state_d = S_EOP_SE0;
                            idx_d   = '0;
                        end
                    end
                    S_UNDR: begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd7) begin
                            state_d = S_EOP_SE0;
                            idx_d   = '0;
                        end
                    end
                    S_EOP_SE0: begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd1) begin
                            state_d = S_EOP_J;
                            idx_d   = '0;
                        end
                    end
                    S_EOP_J: begin
                        state_d     = S_IDLE;
                        oe_d        = 1'b0;
                        done_d      = 1'b1;
                        undr_d      = undr_pend_q;
                        undr_pend_d = 1'b0;
                    end
                    default: state_d = S_IDLE;
                endcase
                // entering bit 0 of a payload byte is where the byte is due
                if (state_d == S_DATA && idx_d == 4'd0) begin
                    if (tx_valid) begin
                        load_byte = 1'b1;
                        sh_d      = tx_data;
                        left_d    = left_q - 11'd1;
                    end else begin
                        state_d     = S_UNDR;
                        undr_pend_d = 1'b1;
                    end
                end
                case (state_d)
                    S_SYNC:  nb = (idx_d == 4'd7);
                    S_PID:   nb = pid_q[idx_d[2:0]];
                    S_TOKEN: nb = tok_q[idx_d];
                    S_CRC5:  nb = ~crc5_q[3'd4 - idx_d[2:0]];
                    S_DATA:  nb = sh_d[idx_d[2:0]];
                    S_CRC16: nb = ~crc16_q[4'd15 - idx_d];
                    S_UNDR:  nb = 1'b1;
                    default: nb = 1'b0;
                endcase
                case (state_d)
                    S_SYNC, S_PID, S_TOKEN, S_CRC5, S_DATA, S_CRC16: begin
                        line_d = nb ? line_q : ~line_q;
                        ones_d = nb ? ones_q + 3'd1 : 3'd0;
                    end
                    S_UNDR: begin
                        line_d = line_q;
                        ones_d = '0;
                    end
                    S_EOP_SE0: se0_d = 1'b1;
                    default: begin
                        se0_d  = 1'b0;
                        line_d = 1'b1;
                    end
                endcase
                if (state_d == S_TOKEN) crc5_d = crc5_step(crc5_q, nb);
                if (state_d == S_DATA)  crc16_d = crc16_step(crc16_q, nb);
            end
        end
    end

    always_comb begin
        tx_ready = load_byte;
        busy     = (state_q != S_IDLE);
        tx_oe    = oe_q;
        tx_dp    = !se0_q && (line_q == fs_q);
        tx_dm    = !se0_q && (line_q != fs_q);
        done     = done_q;
        underrun = undr_q;
    end
endmodule
